// File: rtl/inst_rom_ctrl.sv
// Instruction ROM controller: boot-time loading of a word-addressed memory,
// then single-cycle-latency instruction fetch with alignment/range faults.
// Optional macro IMEM_RANGE_CHECK_EN enables the upper-pc-bit range fault;
// without it the fetch address wraps modulo DEPTH words.
module inst_rom_ctrl #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          romCe,
    input  logic [31:0]   pc,
    input  logic          loadEn,
    input  logic [AW-1:0] loadAddr,
    input  logic [31:0]   loadData,
    input  logic          loadDone,
    output logic [31:0]   inst,
    output logic          instValid,
    output logic          ready,
    output logic          misalign,
    output logic          rangeErr,
    output logic [AW:0]   loadCnt
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q;
    logic [31:0]   inst_q;
    logic          inst_valid_q;
    logic          misalign_q;
    logic          range_err_q;
    logic [AW:0]   load_cnt_q;

    // Instruction storage; deliberately not reset so contents survive rst.
    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] fetch_addr_c;
    logic          misalign_c;
    logic          range_fault_c;

    assign fetch_addr_c = pc[AW+1:2];
    assign misalign_c   = |pc[1:0];

`ifdef IMEM_RANGE_CHECK_EN
    // Any set bit above the word-address field points past the memory.
    assign range_fault_c = |pc[31:AW+2];
`else
    // Upper pc bits are ignored; the fetch address wraps.
    logic unused_pc_hi_c;
    assign unused_pc_hi_c = ^pc[31:AW+2];
    assign range_fault_c  = 1'b0;
`endif

    // Boot-load write port; reset and RUN state block writes.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == BOOT) && loadEn) begin
            mem_q[loadAddr] <= loadData;
        end
    end

    // Control FSM with registered fetch outputs and load counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            range_err_q  <= 1'b0;
            load_cnt_q   <= '0;
        end else begin
            inst_q       <= NOP;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            range_err_q  <= 1'b0;
            case (state_q)
                BOOT: begin
                    if (loadEn && (load_cnt_q != CNT_MAX)) begin
                        load_cnt_q <= load_cnt_q + (AW+1)'(1);
                    end
                    if (loadDone) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (romCe) begin
                        if (misalign_c) begin
                            misalign_q <= 1'b1;
                        end else if (range_fault_c) begin
                            range_err_q <= 1'b1;
                        end else begin
                            inst_q       <= mem_q[fetch_addr_c];
                            inst_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    assign inst      = inst_q;
    assign instValid = inst_valid_q;
    assign ready     = (state_q == RUN);
    assign misalign  = misalign_q;
    assign rangeErr  = range_err_q;
    assign loadCnt   = load_cnt_q;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Self-checking bench for inst_rom_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_inst_rom_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;
    localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef IMEM_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          romCe;
    logic [31:0]   pc;
    logic          loadEn;
    logic [AW-1:0] loadAddr;
    logic [31:0]   loadData;
    logic          loadDone;
    logic [31:0]   inst;
    logic          instValid;
    logic          ready;
    logic          misalign;
    logic          rangeErr;
    logic [AW:0]   loadCnt;

    inst_rom_ctrl #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk      (clk),
        .rst      (rst),
        .romCe    (romCe),
        .pc       (pc),
        .loadEn   (loadEn),
        .loadAddr (loadAddr),
        .loadData (loadData),
        .loadDone (loadDone),
        .inst     (inst),
        .instValid(instValid),
        .ready    (ready),
        .misalign (misalign),
        .rangeErr (rangeErr),
        .loadCnt  (loadCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Behavioural model state
    bit          m_run = 1'b0;
    int unsigned m_cnt = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    logic [31:0] e_inst;
    bit          e_valid, e_mis, e_rng, e_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model of one clock edge from the specification's rules.
    task automatic model_edge(input bit r, input bit ce, input logic [31:0] p,
                              input bit le, input int unsigned la, input logic [31:0] ld,
                              input bit dn);
        int unsigned word;
        e_inst  = NOP;
        e_valid = 1'b0;
        e_mis   = 1'b0;
        e_rng   = 1'b0;
        e_known = 1'b1;
        if (r) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run) begin
            if (le) begin
                m_mem[la] = ld;
                m_wr[la]  = 1'b1;
                if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
            end
            if (dn) m_run = 1'b1;
        end else if (ce) begin
            if ((p % 4) != 0) begin
                e_mis = 1'b1;
            end else if (RANGE_CHK && (p >= DEPTH * 4)) begin
                e_rng = 1'b1;
            end else begin
                word    = (p / 4) % DEPTH;
                e_valid = 1'b1;
                e_inst  = m_mem[word];
                e_known = m_wr[word];
            end
        end
    endtask

    // Drive one cycle, advance the model, then check every output after the edge.
    task automatic step(input bit r, input bit ce, input logic [31:0] p,
                        input bit le, input int unsigned la, input logic [31:0] ld,
                        input bit dn);
        @(negedge clk);
        rst      = r;
        romCe    = ce;
        pc       = p;
        loadEn   = le;
        loadAddr = AW'(la);
        loadData = ld;
        loadDone = dn;
        model_edge(r, ce, p, le, la, ld, dn);
        @(posedge clk);
        #1;
        check_eq("ready",     32'(ready),     32'(m_run));
        check_eq("instValid", 32'(instValid), 32'(e_valid));
        check_eq("misalign",  32'(misalign),  32'(e_mis));
        check_eq("rangeErr",  32'(rangeErr),  32'(e_rng));
        check_eq("loadCnt",   32'(loadCnt),   m_cnt);
        if (e_known) check_eq("inst", inst, e_inst);
    endtask

    initial begin
        int unsigned kind;
        logic [31:0] rp;
        for (int i = 0; i < DEPTH; i++) begin
            m_wr[i]  = 1'b0;
            m_mem[i] = 32'h0;
        end
        rst = 1'b1; romCe = 1'b0; pc = '0; loadEn = 1'b0;
        loadAddr = '0; loadData = '0; loadDone = 1'b0;

        // Reset, with other controls asserted to confirm rst overrides them
        step(1, 1, 32'h0, 1, 0, 32'hDEAD_BEEF, 1);
        step(1, 0, 32'h0, 0, 0, 32'h0, 0);

        // Boot load of four words, loadDone on its own cycle
        step(0, 0, 32'h0, 1, 0, 32'h11, 0);
        step(0, 0, 32'h0, 1, 1, 32'h22, 0);
        step(0, 0, 32'h0, 1, 2, 32'h33, 0);
        step(0, 1, 32'h4, 1, 3, 32'h44, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1);
        check_eq("boot_cnt4", 32'(loadCnt), 32'd4);

        // Back-to-back fetch stream
        step(0, 1, 32'h0, 0, 0, 32'h0, 0);
        check_eq("fetch0", inst, 32'h11);
        step(0, 1, 32'h4, 0, 0, 32'h0, 0);
        step(0, 1, 32'h8, 0, 0, 32'h0, 0);
        step(0, 1, 32'hC, 0, 0, 32'h0, 0);
        check_eq("fetch12", inst, 32'h44);

        // Misaligned fetch, then idle clears the flag
        step(0, 1, 32'h6, 0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 0);

        // Out-of-range fetch (wraps to word 0 without range checking)
        step(0, 1, 32'h400, 0, 0, 32'h0, 0);
        // Loads in RUN are ignored
        step(0, 1, 32'h4, 1, 1, 32'hBAD0_BAD0, 1);

        // Reset mid-stream, boot write with concurrent fetch, then refetch
        step(0, 1, 32'h8, 0, 0, 32'h0, 0);
        step(1, 1, 32'hC, 0, 0, 32'h0, 0);
        step(0, 1, 32'd20, 1, 5, 32'hAB, 0);
        step(0, 0, 32'h0, 0, 0, 32'h0, 1);
        step(0, 1, 32'd20, 0, 0, 32'h0, 0);
        check_eq("boot_ab", inst, 32'hAB);
        step(0, 1, 32'h4, 0, 0, 32'h0, 0);
        check_eq("retained", inst, 32'h22);

        // Full load past DEPTH to hit counter saturation; last write with loadDone
        step(1, 0, 32'h0, 0, 0, 32'h0, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 32'h0, 1, i, $urandom, 0);
        step(0, 0, 32'h0, 1, 7, $urandom, 0);
        step(0, 0, 32'h0, 1, 200, $urandom, 1);
        check_eq("cnt_sat", 32'(loadCnt), DEPTH);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0, 1:    rp = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
                2:       rp = {20'h0, 12'($urandom)} | 32'h1;
                default: rp = $urandom;
            endcase
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), rp,
                 ($urandom_range(0, 2) == 0), $urandom_range(0, DEPTH - 1), $urandom,
                 ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
